aer_spike_demux: RTL and testbench
==================================

# aer_spike_demux

Address-event receiver and distributor for the LIF neuron array. It accepts a serial stream of address-event (AER) packets, each carrying a target neuron index and a signed synaptic weight, through a valid/ready handshake. It buffers up to two events and routes each one to its addressed neuron channel as a registered one-cycle strobe with data. It is the fan-out counterpart of the selection muxes that merge neuron signals onto shared paths, and it sits between the event bus and the per-neuron input-current ports.

## Interface
- `NUM_OUT`, 4: number of neuron output channels (≥2).
- `ADDR_W`, 2: event address width. Addresses `0..2^ADDR_W-1` are legal on the port; only addresses below `NUM_OUT` are routable.
- `WIDTH`, 12: signed weight width. Matches the neuron current datapath.

- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: event present.
- `in_ready`, output, 1: block can accept an event.
- `in_addr`, input, `ADDR_W`: target channel.
- `in_data`, input, signed `WIDTH`: synaptic weight.
- `out_stall`, input, 1: downstream hold. While high, no event is dispatched.
- `out_valid`, output, `NUM_OUT`: one-hot per-channel strobe.
- `out_data`, output, `NUM_OUT*WIDTH`: flattened per-channel weights. Channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `err_count`, output, 8: saturating count of events with an unroutable address.

## Operation
- **Buffer.** 2-entry FIFO of {addr, data}. Its occupancy is the state machine:
  - EMPTY → ONE on push.
  - ONE → FULL on push without pop.
  - ONE → EMPTY on pop without push.
  - ONE → ONE on simultaneous push and pop.
  - FULL → ONE on pop. No push is possible in FULL.
- **Handshake.**
  - `in_ready = (state != FULL)`, a pure function of registered state.
  - Push occurs when `in_valid && in_ready` at a rising edge.
  - `in_addr` and `in_data` are ignored when not pushed.
- **Pop condition.** Pop occurs when `state != EMPTY && !out_stall`. Only the head entry is dispatched. An entry pushed on a given edge cannot be popped on that same edge.
- **Dispatch of the head {a, d}:**
  - If `a < NUM_OUT`: set `out_valid` bit a to 1 and set `out_data` slice a to d. All other `out_valid` bits are 0.
  - If `a >= NUM_OUT`: `out_valid` is all 0, the event is discarded, and `err_count` increments, saturating at 255.
- **Strobes.** `out_valid` is a single-cycle strobe, cleared on every edge without a routable pop.
- **Data hold.** Each `out_data` slice holds its last written value until overwritten. It is never cleared except by reset.
- **Stall.** `out_stall` high freezes the FIFO head and forces `out_valid` to 0. Pushes continue until FULL.
- **Reset.** `rst` asserted at any time, including mid-burst, immediately sets:
  - state = EMPTY, discarding buffered events;
  - `in_ready` = 1;
  - `out_valid` = 0;
  - `out_data` = 0;
  - `err_count` = 0.
  
  The first push can occur on the first rising edge after `rst` deasserts.

## Timing
- **Latency.** An event pushed at edge n, with no stall and an empty FIFO, produces `out_valid` high during the cycle after edge n+1. That is 2 edges from acceptance to strobe.
- **Throughput.** 1 event per cycle sustained. The state stays in ONE under continuous push and pop.
- **Full condition.** `in_ready` drops the cycle after the FIFO reaches FULL. It rises the cycle after the first pop from FULL.
- **Registered outputs.** `out_valid`, `out_data` and `err_count` are all driven directly from registers, with no combinational path from inputs. `in_ready` depends only on state.

## Structure
- **Shared package** `snn_pkg`, holding:
  - `WIDTH` default;
  - the event struct/typedef {addr, data};
  - the `ERR_MAX = 8'hFF` constant.
- **Sub-module** `event_fifo2`: a 2-entry synchronous FIFO with count/full/empty, parameterised on payload width. The decode/dispatch register stage lives in `aer_spike_demux`.

## Test plan
- **Single event, reset state.** Push addr=2, data=-5 once. Required response:
  - `out_valid` = 4'b0100 exactly one cycle, 2 edges after acceptance;
  - slice 2 = -5;
  - other slices 0.
- **Back-to-back stream.** Push addrs 0,1,2,3 with data 100,200,-300,400 on consecutive cycles. Required response:
  - strobes 0001, 0010, 0100, 1000 on consecutive cycles;
  - `in_ready` never drops.
- **Stall fill.** Hold `out_stall`=1 and push 3 events. Required response:
  - `in_ready` = 0 after the second push; the third event is held at the port.
  - After releasing the stall, all 3 events are dispatched in order with no loss.
- **Unroutable address.** With `NUM_OUT`=3, push addr=3 then addr=1, data=7. Required response:
  - first event: no strobe, `err_count` = 1;
  - second event: `out_valid` = 3'b010, slice 1 = 7.
- **Counter saturation.** Push 260 events at addr=3 (`NUM_OUT`=3). Required response: `err_count` stops at 255.
- **Reset mid-operation.** Assert `rst` asynchronously with FIFO FULL and a strobe active. Required response:
  - outputs go to 0 immediately;
  - `in_ready` = 1;
  - no buffered event appears after release.

Source files
------------

// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-neural-network datapath blocks.
//   WIDTH_DEFAULT  : default signed weight / neuron current width
//   ADDR_W_DEFAULT : default address-event address width
//   ERR_MAX        : saturation ceiling for 8-bit error counters
//   aer_event_t    : {addr, data} address-event at default widths
//   fifo_state_t   : occupancy states of the two-entry event buffer
//   sat_inc()      : saturating increment for 8-bit counters
// ---------------------------------------------------------------------------
package snn_pkg;

  localparam int WIDTH_DEFAULT = 12;
  localparam int ADDR_W_DEFAULT = 2;
  localparam logic [7:0] ERR_MAX = 8'hFF;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] addr;
    logic signed [WIDTH_DEFAULT-1:0] data;
  } aer_event_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'd0,
    FIFO_ONE   = 2'd1,
    FIFO_FULL  = 2'd2
  } fifo_state_t;

  // Counter sticks at ERR_MAX instead of wrapping back to zero.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == ERR_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/event_fifo2.sv
// ---------------------------------------------------------------------------
// event_fifo2
// Two-entry synchronous FIFO whose occupancy is held as an explicit state
// machine (EMPTY / ONE / FULL).
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   push     : write wdata (ignored while full)
//   pop      : drop the head entry (ignored while empty)
//   wdata    : payload to write, W bits
//   rdata    : current head entry, W bits
//   count    : number of stored entries (0..2)
//   full     : two entries stored
//   empty    : no entries stored
// ---------------------------------------------------------------------------
module event_fifo2
  import snn_pkg::*;
#(
  parameter int W = ADDR_W_DEFAULT + WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fifo_state_t state;
  logic [W-1:0] mem [2];
  logic wr_ptr;
  logic rd_ptr;
  logic do_push;
  logic do_pop;

  // Requests that cannot be honoured in the current state are dropped here,
  // so the caller may drive push/pop without looking at full/empty.
  assign do_push = push && (state != FIFO_FULL);
  assign do_pop  = pop && (state != FIFO_EMPTY);

  // Occupancy state machine together with the read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FIFO_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case (state)
        FIFO_EMPTY: begin
          if (do_push) state <= FIFO_ONE;
        end
        FIFO_ONE: begin
          if (do_push && !do_pop)      state <= FIFO_FULL;
          else if (do_pop && !do_push) state <= FIFO_EMPTY;
        end
        FIFO_FULL: begin
          if (do_pop) state <= FIFO_ONE;
        end
        default: state <= FIFO_EMPTY;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (state == FIFO_FULL);
  assign empty = (state == FIFO_EMPTY);

  // Entry count decoded straight from the occupancy state.
  always_comb begin
    count = 2'd0;
    case (state)
      FIFO_ONE:  count = 2'd1;
      FIFO_FULL: count = 2'd2;
      default:   count = 2'd0;
    endcase
  end

endmodule

// File: rtl/aer_spike_demux.sv
// ---------------------------------------------------------------------------
// aer_spike_demux
// Address-event receiver: buffers up to two {addr, weight} events and routes
// each one to its neuron channel as a registered one-cycle strobe with data.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_valid   : event present on in_addr / in_data
//   in_ready   : buffer can take an event (buffer not full)
//   in_addr    : target channel, ADDR_W bits
//   in_data    : signed synaptic weight, WIDTH bits
//   out_stall  : downstream hold, blocks dispatch while high
//   out_valid  : one-hot per-channel strobe, NUM_OUT bits
//   out_data   : per-channel weights, channel i at [i*WIDTH +: WIDTH]
//   err_count  : saturating count of events with an unroutable address
// ---------------------------------------------------------------------------
module aer_spike_demux
  import snn_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic signed [WIDTH-1:0]  in_data,
  input  logic                     out_stall,
  output logic [NUM_OUT-1:0]       out_valid,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [7:0]               err_count
);

  typedef struct packed {
    logic [ADDR_W-1:0]       addr;
    logic signed [WIDTH-1:0] data;
  } event_t;

  event_t     wr_event;
  event_t     head;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic       routable;
  logic [1:0] unused_fifo_count;

  assign wr_event = '{addr: in_addr, data: in_data};

  // in_ready comes only from the buffer's registered occupancy.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  // Only an entry already stored before this edge can be popped, so a fresh
  // push always spends one cycle in the buffer before dispatch.
  assign pop      = !fifo_empty && !out_stall;
  assign routable = (int'(head.addr) < NUM_OUT);

  event_fifo2 #(
    .W($bits(event_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(wr_event),
    .rdata(head),
    .count(unused_fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Dispatch register stage: strobes clear every cycle, data slices hold
  // their last weight, and unroutable events only bump the error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      err_count <= '0;
    end else begin
      out_valid <= '0;
      for (int i = 0; i < NUM_OUT; i++) begin
        if (pop && routable && (int'(head.addr) == i)) begin
          out_valid[i]                <= 1'b1;
          out_data[i*WIDTH +: WIDTH]  <= head.data;
        end
      end
      if (pop && !routable) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_aer_spike_demux.sv
// ---------------------------------------------------------------------------
// tb_aer_spike_demux
// Drives two demux instances (4 and 3 channels) from one event stream. A
// queue-based reference model predicts acceptance, dispatch order, strobe
// timing, held data and error counts; a monitor compares at each negedge.
// ---------------------------------------------------------------------------
module tb_aer_spike_demux;

  localparam int W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [1:0]        in_addr;
  logic signed [W-1:0] in_data;
  logic              out_stall;

  logic              rdy4, rdy3;
  logic [3:0]        ov4;
  logic [2:0]        ov3;
  logic [4*W-1:0]    od4;
  logic [3*W-1:0]    od3;
  logic [7:0]        err4, err3;

  always #5 clk = ~clk;

  aer_spike_demux #(.NUM_OUT(4), .ADDR_W(2), .WIDTH(W)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .in_addr(in_addr), .in_data(in_data), .out_stall(out_stall),
    .out_valid(ov4), .out_data(od4), .err_count(err4)
  );

  aer_spike_demux #(.NUM_OUT(3), .ADDR_W(2), .WIDTH(W)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
    .in_addr(in_addr), .in_data(in_data), .out_stall(out_stall),
    .out_valid(ov3), .out_data(od3), .err_count(err3)
  );

  // Uniform views of both instances so one monitor task serves both.
  logic [3:0]     ovw  [2];
  logic [4*W-1:0] odw  [2];
  logic [7:0]     errw [2];
  logic           rdyw [2];
  assign ovw[0]  = ov4;
  assign ovw[1]  = {1'b0, ov3};
  assign odw[0]  = od4;
  assign odw[1]  = {{W{1'b0}}, od3};
  assign errw[0] = err4;
  assign errw[1] = err3;
  assign rdyw[0] = rdy4;
  assign rdyw[1] = rdy3;

  typedef struct {
    int addr;
    int data;
    int exp_err;
  } exp_t;

  exp_t sb [2][$];
  int   mq_addr[$];
  int   mq_data[$];
  int   nout [2] = '{4, 3};
  int   err_model [2];
  int   exp_mask [2];
  int   chan_data [2][4];
  int   last_err [2];
  int   checks = 0;
  int   passes = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic v, input int a, input int d, input logic s);
    in_valid  = v;
    in_addr   = 2'(a);
    in_data   = W'(d);
    out_stall = s;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue of at most two events; pop when it holds
  // something and downstream is not stalled, push when it has room.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_addr.delete();
      mq_data.delete();
      for (int d = 0; d < 2; d++) begin
        sb[d].delete();
        err_model[d] = 0;
        exp_mask[d]  = 0;
      end
    end else begin
      bit pop_now;
      bit push_now;
      int a;
      pop_now  = (mq_addr.size() > 0) && !out_stall;
      push_now = in_valid && (mq_addr.size() < 2);
      for (int d = 0; d < 2; d++) exp_mask[d] = 0;
      if (pop_now) begin
        a = mq_addr.pop_front();
        void'(mq_data.pop_front());
        for (int d = 0; d < 2; d++)
          if (a < nout[d]) exp_mask[d] = 1 << a;
      end
      if (push_now) begin
        mq_addr.push_back(int'(in_addr));
        mq_data.push_back(int'(in_data));
        for (int d = 0; d < 2; d++) begin
          if (int'(in_addr) >= nout[d] && err_model[d] < 255) err_model[d]++;
          sb[d].push_back('{int'(in_addr), int'(in_data), err_model[d]});
        end
      end
    end
  end

  task automatic monitorDut(input int d);
    exp_t e;
    checkOutput($sformatf("strobe_timing_n%0d", nout[d]), ovw[d], exp_mask[d]);
    if (ovw[d] != 0 || errw[d] != 8'(last_err[d])) begin
      if (ovw[d] != 0)
        while (sb[d].size() > 0 && sb[d][0].addr >= nout[d] && sb[d][0].exp_err == 255)
          void'(sb[d].pop_front());
      if (sb[d].size() == 0) begin
        checkOutput($sformatf("unexpected_output_n%0d", nout[d]), 1, 0);
      end else begin
        e = sb[d].pop_front();
        checkOutput($sformatf("err_count_n%0d", nout[d]), errw[d], e.exp_err);
        if (e.addr < nout[d]) begin
          checkOutput($sformatf("strobe_chan_n%0d", nout[d]), ovw[d], 1 << e.addr);
          chan_data[d][e.addr] = e.data;
        end else begin
          checkOutput($sformatf("unroutable_quiet_n%0d", nout[d]), ovw[d], 0);
        end
      end
      last_err[d] = int'(errw[d]);
    end
    for (int c = 0; c < nout[d]; c++)
      checkOutput($sformatf("slice%0d_n%0d", c, nout[d]),
                  int'($signed(odw[d][c*W +: W])), chan_data[d][c]);
    checkOutput($sformatf("in_ready_n%0d", nout[d]), rdyw[d], (mq_addr.size() < 2) ? 1 : 0);
  endtask

  // Monitor: compare both instances away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        last_err[d] = 0;
        for (int c = 0; c < 4; c++) chan_data[d][c] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) monitorDut(d);
    end
  end

  int b2b_data [4] = '{100, 200, -300, 400};

  initial begin
    in_valid = 1'b0; in_addr = '0; in_data = '0; out_stall = 1'b0; rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", ov4, 0);
    checkOutput("reset_out_data", od4 == '0, 1);
    checkOutput("reset_err", err3, 0);
    checkOutput("reset_in_ready", rdy4, 1);
    rst = 1'b0;

    // Single event: strobe exactly two edges after acceptance.
    applyStimulus(1'b1, 2, -5, 1'b0);
    in_valid = 1'b0;
    checkOutput("single_no_early_strobe", ov4, 0);
    @(posedge clk); #1;
    checkOutput("single_strobe", ov4, 4'b0100);
    checkOutput("single_slice2", int'($signed(od4[2*W +: W])), -5);
    checkOutput("single_slice0", int'($signed(od4[0 +: W])), 0);
    @(posedge clk); #1;
    checkOutput("single_strobe_one_cycle", ov4, 0);
    repeat (2) @(posedge clk); #1;

    // Unroutable address on the 3-channel instance.
    applyStimulus(1'b1, 3, 9, 1'b0);
    applyStimulus(1'b1, 1, 7, 1'b0);
    in_valid = 1'b0;
    checkOutput("unroutable_no_strobe", ov3, 0);
    checkOutput("unroutable_err", err3, 1);
    @(posedge clk); #1;
    checkOutput("routable_after_err", ov3, 3'b010);
    checkOutput("routable_slice1", int'($signed(od3[W +: W])), 7);
    repeat (3) @(posedge clk); #1;

    // Back-to-back stream: ready must never drop.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i, b2b_data[i], 1'b0);
      checkOutput("b2b_in_ready", rdy4, 1);
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Stall fill: third event held at the port until the stall releases.
    applyStimulus(1'b1, 0, 11, 1'b1);
    checkOutput("stall_ready_after_1", rdy4, 1);
    applyStimulus(1'b1, 1, 22, 1'b1);
    checkOutput("stall_ready_after_2", rdy4, 0);
    applyStimulus(1'b1, 2, 33, 1'b1);
    checkOutput("stall_third_held", rdy4, 0);
    applyStimulus(1'b1, 2, 33, 1'b0);
    checkOutput("stall_ready_after_pop", rdy4, 1);
    applyStimulus(1'b1, 2, 33, 1'b0);
    in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Randomized traffic with random stalls.
    for (int i = 0; i < 500; i++)
      applyStimulus(1'($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 4095)) - 2048, 1'($urandom_range(0, 3) == 0));
    in_valid = 1'b0; out_stall = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Error counter saturation.
    for (int i = 0; i < 260; i++) applyStimulus(1'b1, 3, i, 1'b0);
    in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    checkOutput("err_saturated", err3, 255);
    checkOutput("err_none_n4", err4, 0);

    // Reset with the buffer full under stall.
    applyStimulus(1'b1, 1, 55, 1'b1);
    applyStimulus(1'b1, 2, 66, 1'b1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_full_ready", rdy4, 1);
    checkOutput("rst_full_data", od4 == '0, 1);
    checkOutput("rst_full_err", err3, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_stall = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      checkOutput("rst_no_ghost", ov4, 0);
    end

    // Reset while a strobe is active.
    applyStimulus(1'b1, 3, 77, 1'b0);
    applyStimulus(1'b1, 0, 88, 1'b0);
    in_valid = 1'b0;
    checkOutput("pre_rst_strobe", ov4, 4'b1000);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_strobe_valid", ov4, 0);
    checkOutput("rst_strobe_data", od4 == '0, 1);
    checkOutput("rst_strobe_ready", rdy4, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      checkOutput("rst2_no_ghost", ov4, 0);
    end

    for (int d = 0; d < 2; d++) begin
      while (sb[d].size() > 0 && sb[d][0].addr >= nout[d] && sb[d][0].exp_err == 255)
        void'(sb[d].pop_front());
      checkOutput($sformatf("scoreboard_drained_n%0d", nout[d]), sb[d].size(), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
